stopwatch_run_controller: RTL and testbench

Control-path sequencer for the four-digit hexadecimal stopwatch counter. It turns raw board pushbuttons into debounced, single-cycle commands and runs the run/pause/lap/overflow state machine. It owns the once-per-tick prescaler and drives the digit datapath through count_enable, count_clear and display_hold. The digit datapath never sees raw buttons or the 50 MHz prescale logic directly.

---
 rtl/stopwatch_run_controller.sv | 183 ++++++++++++++++++
 tb/tb_stopwatch_run_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_run_controller.sv
// Control path for the four-digit hex stopwatch: debounced button commands,
// once-per-tick prescaler and the run/pause/lap/overflow sequencer.
module stopwatch_run_controller #(
    parameter int unsigned CLOCK_CYCLE     = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_stop_button,
    input  logic       lap_button,
    input  logic       clear_button,
    input  logic       count_at_max,
    output logic       count_enable,
    output logic       count_clear,
    output logic       display_hold,
    output logic       running,
    output logic       overflow,
    output logic [2:0] state
);
    localparam int unsigned PW = (CLOCK_CYCLE > 1) ? $clog2(CLOCK_CYCLE) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_CYCLE - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned BTN_SS  = 0;
    localparam int unsigned BTN_LAP = 1;
    localparam int unsigned BTN_CLR = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUNNING  = 3'd1,
        PAUSED   = 3'd2,
        LAP      = 3'd3,
        OVERFLOW = 3'd4
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;
    logic [2:0]    raw_btn;
    logic [2:0]    sync_a;
    logic [2:0]    sync_b;
    logic [2:0]    db_level;
    logic [2:0]    db_level_d;
    logic [2:0]    press;
    logic [DW-1:0] db_cnt [3];
    logic [PW-1:0] presc;
    logic          ev_ss;
    logic          ev_lap;
    logic          ev_clr;
    logic          counting;
    logic          tick;
    logic          clear_req;
    logic          enable_nxt;
    logic          running_nxt;
    logic          overflow_nxt;
    logic          hold_nxt;

    assign raw_btn = {clear_button, lap_button, start_stop_button};
    assign ev_ss   = press[BTN_SS];
    assign ev_lap  = press[BTN_LAP];
    assign ev_clr  = press[BTN_CLR];
    assign state   = cur_state;

    // Per button: 2-flop synchroniser, consecutive-mismatch debouncer, rising-edge pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a     <= '0;
            sync_b     <= '0;
            db_level   <= '0;
            db_level_d <= '0;
            press      <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a     <= raw_btn;
            sync_b     <= sync_a;
            db_level_d <= db_level;
            press      <= db_level & ~db_level_d;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync_b[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync_b[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign counting = (cur_state == RUNNING) || (cur_state == LAP);
    assign tick     = counting && (presc == PRESC_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (clear_req || nxt_state == IDLE || nxt_state == OVERFLOW) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else if (counting) begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state    <= IDLE;
            count_enable <= 1'b0;
            count_clear  <= 1'b0;
            display_hold <= 1'b0;
            running      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            count_enable <= enable_nxt;
            count_clear  <= clear_req;
            display_hold <= hold_nxt;
            running      <= running_nxt;
            overflow     <= overflow_nxt;
        end
    end

    // An at-max tick outranks every button; otherwise clear > start_stop > lap.
    always_comb begin
        nxt_state = cur_state;
        clear_req = 1'b0;
        case (cur_state)
            IDLE: begin
                if (ev_clr) begin
                    clear_req = 1'b1;
                end else if (ev_ss) begin
                    nxt_state = RUNNING;
                end
            end
            RUNNING: begin
                if (tick && count_at_max) begin
                    nxt_state = OVERFLOW;
                end else if (ev_ss) begin
                    nxt_state = PAUSED;
                end else if (ev_lap) begin
                    nxt_state = LAP;
                end
            end
            LAP: begin
                if (tick && count_at_max) begin
                    nxt_state = OVERFLOW;
                end else if (ev_ss) begin
                    nxt_state = PAUSED;
                end else if (ev_lap) begin
                    nxt_state = RUNNING;
                end
            end
            PAUSED: begin
                if (ev_clr) begin
                    nxt_state = IDLE;
                    clear_req = 1'b1;
                end else if (ev_ss) begin
                    nxt_state = RUNNING;
                end
            end
            OVERFLOW: begin
                if (ev_clr) begin
                    nxt_state = IDLE;
                    clear_req = 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                clear_req = 1'b1;
            end
        endcase
    end

    always_comb begin
        enable_nxt   = tick && !count_at_max;
        running_nxt  = (nxt_state == RUNNING) || (nxt_state == LAP);
        overflow_nxt = (nxt_state == OVERFLOW);
        hold_nxt     = (nxt_state == LAP);
    end

endmodule

// File: tb/tb_stopwatch_run_controller.sv
// Self-checking bench for stopwatch_run_controller: directed timing sequences,
// a command/response table and randomized button traffic against a reference model.
module tb_stopwatch_run_controller;
    localparam int unsigned CC  = 4;
    localparam int unsigned DB  = 3;
    // FSM acts on edge (first edge sampling a pressed level) + ACT.
    localparam int          ACT = 2 + DB + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_stop_button;
    logic       lap_button;
    logic       clear_button;
    logic       count_at_max;
    logic       count_enable;
    logic       count_clear;
    logic       display_hold;
    logic       running;
    logic       overflow;
    logic [2:0] state;

    stopwatch_run_controller #(
        .CLOCK_CYCLE    (CC),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start_stop_button(start_stop_button),
        .lap_button       (lap_button),
        .clear_button     (clear_button),
        .count_at_max     (count_at_max),
        .count_enable     (count_enable),
        .count_clear      (count_clear),
        .display_hold     (display_hold),
        .running          (running),
        .overflow         (overflow),
        .state            (state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] mask;      // {clear, lap, start_stop}
        logic       at_max;
        int         exp_state;
        logic       exp_run;
        logic       exp_hold;
        logic       exp_ovf;
        int         exp_clears;
    } vec_t;

    vec_t vecs [20];

    int checks    = 0;
    int failures  = 0;
    int edge_no   = 0;
    int ce_seen   = 0;
    int cc_seen   = 0;
    int hold_left = 0;

    // Reference model: abstract state, tick phase and events scheduled by latency.
    int m_state = 0;
    int m_phase = 0;
    int m_ce    = 0;
    int m_cc    = 0;
    int ev_at [3];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_no);
        end
    endtask

    task automatic set_buttons(input logic [2:0] m);
        {clear_button, lap_button, start_stop_button} = m;
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        set_buttons(m);
        hold_left = hold;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        edge_no++;
        if (count_enable) ce_seen++;
        if (count_clear) cc_seen++;
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) set_buttons(3'b000);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_state(input int target, input int bound, output int edges);
        edges = -1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (int'(state) == target) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic wait_ce(input int bound, output int edges);
        edges = -1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (count_enable) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic model_edge(input bit e_ss, input bit e_lap, input bit e_clr, input bit at_max);
        bit counting;
        bit tick;
        int nxt;
        counting = (m_state == 1) || (m_state == 3);
        tick     = counting && (m_phase == CC - 1);
        m_ce     = (tick && !at_max) ? 1 : 0;
        m_cc     = 0;
        nxt      = m_state;
        if (tick && at_max) begin
            nxt = 4;
        end else begin
            case (m_state)
                0: if (e_clr) m_cc = 1; else if (e_ss) nxt = 1;
                1: if (e_ss) nxt = 2; else if (e_lap) nxt = 3;
                3: if (e_ss) nxt = 2; else if (e_lap) nxt = 1;
                2: if (e_clr) begin nxt = 0; m_cc = 1; end else if (e_ss) nxt = 1;
                4: if (e_clr) begin nxt = 0; m_cc = 1; end
                default: nxt = 0;
            endcase
        end
        if (counting) m_phase = (m_phase + 1) % CC;
        if (nxt == 0 || nxt == 4) m_phase = 0;
        m_state = nxt;
    endtask

    task automatic rstep();
        bit e_ss;
        bit e_lap;
        bit e_clr;
        @(posedge clock);
        edge_no++;
        e_ss  = (ev_at[0] == edge_no);
        e_lap = (ev_at[1] == edge_no);
        e_clr = (ev_at[2] == edge_no);
        model_edge(e_ss, e_lap, e_clr, count_at_max);
        #1;
        check("rnd_state", int'(state), m_state);
        check("rnd_running", int'(running), (m_state == 1 || m_state == 3) ? 1 : 0);
        check("rnd_overflow", int'(overflow), (m_state == 4) ? 1 : 0);
        check("rnd_hold", int'(display_hold), (m_state == 3) ? 1 : 0);
        check("rnd_enable", int'(count_enable), m_ce);
        check("rnd_clear", int'(count_clear), m_cc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int base;
        logic [2:0] mask;
        bit glitch;
        int hold;
        int gap;

        vecs[0]  = '{3'b001, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{3'b010, 1'b0, 3, 1'b1, 1'b1, 1'b0, 0};
        vecs[2]  = '{3'b010, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
        vecs[3]  = '{3'b010, 1'b0, 3, 1'b1, 1'b1, 1'b0, 0};
        vecs[4]  = '{3'b001, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0};
        vecs[5]  = '{3'b010, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0};
        vecs[6]  = '{3'b001, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
        vecs[7]  = '{3'b100, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
        vecs[8]  = '{3'b011, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0};
        vecs[9]  = '{3'b101, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{3'b100, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{3'b101, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{3'b001, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
        vecs[13] = '{3'b000, 1'b1, 4, 1'b0, 1'b0, 1'b1, 0};
        vecs[14] = '{3'b001, 1'b1, 4, 1'b0, 1'b0, 1'b1, 0};
        vecs[15] = '{3'b010, 1'b1, 4, 1'b0, 1'b0, 1'b1, 0};
        vecs[16] = '{3'b100, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1};
        vecs[17] = '{3'b011, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
        vecs[18] = '{3'b010, 1'b0, 3, 1'b1, 1'b1, 1'b0, 0};
        vecs[19] = '{3'b110, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};

        reset = 1'b1;
        set_buttons(3'b000);
        count_at_max = 1'b0;
        settle(3);
        check("reset_state", int'(state), 0);
        check("reset_outputs", int'({count_enable, count_clear, display_hold, running, overflow}), 0);
        #2 reset = 1'b0;
        settle(2);

        // Start timing and tick period
        press(3'b001, 10);
        wait_state(1, 20, e);
        check("start_latency", e, ACT + 1);
        check("start_running", int'(running), 1);
        wait_ce(10, e);
        check("first_enable", e, CC);
        for (int k = 0; k < 2; k++) begin
            wait_ce(10, e);
            check("enable_period", e, CC);
        end
        press(3'b010, 2);
        settle(14);
        check("glitch_state", int'(state), 1);
        check("glitch_hold", int'(display_hold), 0);

        // Pause with prescaler held at 2, resume
        wait_ce(10, e);
        check("align_enable", (e > 0) ? 1 : 0, 1);
        settle(3);
        press(3'b001, 5);
        wait_state(2, 20, e);
        check("pause_latency", e, ACT + 1);
        base = ce_seen;
        settle(12);
        check("paused_no_enable", ce_seen - base, 0);
        press(3'b001, 5);
        wait_state(1, 20, e);
        check("resume_latency", e, ACT + 1);
        wait_ce(10, e);
        check("resume_enable", e, 2);
        settle(4);
        press(3'b001, 5);
        wait_state(2, 20, e);
        settle(8);
        base = cc_seen;
        press(3'b100, 5);
        wait_state(0, 20, e);
        check("paused_clear_latency", e, ACT + 1);
        settle(6);
        check("paused_clear_pulses", cc_seen - base, 1);

        // Lap keeps the count period
        press(3'b001, 5);
        wait_state(1, 20, e);
        settle(8);
        press(3'b010, 5);
        wait_state(3, 20, e);
        check("lap_latency", e, ACT + 1);
        check("lap_hold", int'(display_hold), 1);
        wait_ce(10, e);
        wait_ce(10, e);
        check("lap_period", e, CC);
        check("lap_running", int'(running), 1);
        settle(6);
        press(3'b010, 5);
        wait_state(1, 20, e);
        check("unlap_hold", int'(display_hold), 0);

        // start_stop coinciding with an at-max tick goes to OVERFLOW
        settle(6);
        wait_ce(10, e);
        step();
        press(3'b001, 5);
        settle(4);
        count_at_max = 1'b1;
        base = ce_seen;
        wait_state(4, 10, e);
        check("ovf_beats_ss", e, 3);
        check("ovf_no_enable", ce_seen - base, 0);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_running", int'(running), 0);
        settle(6);
        base = ce_seen;
        press(3'b001, 5);
        settle(14);
        press(3'b010, 5);
        settle(14);
        check("ovf_ignores", int'(state), 4);
        check("ovf_never_enable", ce_seen - base, 0);
        base = cc_seen;
        press(3'b100, 5);
        wait_state(0, 20, e);
        check("ovf_clear_latency", e, ACT + 1);
        settle(4);
        check("ovf_clear_pulses", cc_seen - base, 1);
        check("ovf_cleared", int'(overflow), 0);

        // Command table
        for (int v = 0; v < 20; v++) begin
            count_at_max = vecs[v].at_max;
            base = cc_seen;
            press(vecs[v].mask, 5);
            settle(16);
            check($sformatf("tbl%0d_state", v), int'(state), vecs[v].exp_state);
            check($sformatf("tbl%0d_running", v), int'(running), int'(vecs[v].exp_run));
            check($sformatf("tbl%0d_hold", v), int'(display_hold), int'(vecs[v].exp_hold));
            check($sformatf("tbl%0d_overflow", v), int'(overflow), int'(vecs[v].exp_ovf));
            check($sformatf("tbl%0d_clears", v), cc_seen - base, vecs[v].exp_clears);
        end
        count_at_max = 1'b0;

        // Async reset mid-LAP with a press still in debounce
        press(3'b010, 5);
        wait_state(3, 20, e);
        check("pre_reset_lap", int'(state), 3);
        press(3'b001, 5);
        settle(3);
        #3 reset = 1'b1;
        set_buttons(3'b000);
        hold_left = 0;
        #1;
        check("async_reset_state", int'(state), 0);
        check("async_reset_outputs", int'({count_enable, count_clear, display_hold, running, overflow}), 0);
        #2 reset = 1'b0;
        base = cc_seen;
        settle(12);
        check("post_reset_state", int'(state), 0);
        check("post_reset_no_clear", cc_seen - base, 0);

        // Randomized traffic against the reference model
        reset = 1'b1;
        step();
        #2 reset = 1'b0;
        m_state = 0;
        m_phase = 0;
        for (int b = 0; b < 3; b++) ev_at[b] = -1;
        settle(2);
        for (int op = 0; op < 150; op++) begin
            mask   = 3'($urandom_range(1, 7));
            glitch = ($urandom_range(0, 4) == 0);
            hold   = glitch ? int'($urandom_range(1, DB - 1)) : int'($urandom_range(DB, DB + 4));
            gap    = int'($urandom_range(6, 12));
            count_at_max = ($urandom_range(0, 5) == 0);
            set_buttons(mask);
            if (!glitch) begin
                for (int b = 0; b < 3; b++) begin
                    if (mask[b]) ev_at[b] = edge_no + 1 + ACT;
                end
            end
            for (int c = 0; c < hold + gap; c++) begin
                if (c == hold) set_buttons(3'b000);
                rstep();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
